// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial two's-complement subtractor. It computes inA - inB one bit per
// clock, LSB first, with one full-subtractor cell and a registered borrow.
// It is a small subtract/compare unit that sits beside the ALU.
//
// Handshake: while IDLE, a high start on a rising edge captures inA/inB.
// WIDTH edges later the result registers update and done pulses for one
// cycle. busy is high for the whole time the operands are being shifted.
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous, active-high reset (has priority over start)
//   start  request; sampled only while not busy
//   inA    minuend, captured on the accepting edge
//   inB    subtrahend, captured on the accepting edge
//   busy   high while a subtraction is in progress
//   done   one-cycle pulse when diff/bout/zero/ovf update
//   diff   inA - inB mod 2^WIDTH
//   bout   final borrow; 1 iff inA < inB (unsigned)
//   zero   1 iff diff == 0
//   ovf    signed overflow of inA - inB
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  // A WIDTH of 1 still needs a 1-bit counter.
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t state, state_next;

  // Operand shift registers. They are consumed from bit 0.
  logic [WIDTH-1:0] a_sh, b_sh;
  // The result fills from the MSB side, so after WIDTH shifts bit 0 holds
  // the LSB of the difference.
  logic [WIDTH-1:0] r_sh;
  logic             br;
  logic [CNT_W-1:0] count;
  // Sign bits of the original operands. They are kept for the overflow
  // flag because the shift registers no longer hold them at completion.
  logic             a_msb, b_msb;

  // Full-subtractor cell and per-step next values.
  logic             a0, b0;
  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] r_next;
  logic             last;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned. Without the defaults, synthesis infers latches.
    state_next = state;
    a0         = a_sh[0];
    b0         = b_sh[0];
    d_bit      = a0 ^ b0 ^ br;
    br_next    = (~a0 & b0) | (~a0 & br) | (b0 & br);
    r_next     = {d_bit, r_sh[WIDTH-1:1]};
    last       = (count == CNT_W'(WIDTH - 1));

    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // busy decodes directly from the state register, so it is glitch-free.
  // It is also never high in the same cycle as done, because done is only
  // set on the edge that returns the FSM to IDLE.
  assign busy = (state == SHIFT);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples the values from before the edge, whatever
    // order the statements appear in.
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      br    <= 1'b0;
      count <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      zero  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= inA;
            b_sh  <= inB;
            r_sh  <= '0;
            br    <= 1'b0;
            count <= '0;
            a_msb <= inA[WIDTH-1];
            b_msb <= inB[WIDTH-1];
          end
        end

        SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          r_sh  <= r_next;
          br    <= br_next;
          count <= count + 1'b1;

          // Completion: take the result from this step's combinational
          // values, not from r_sh/br, which hold the previous step.
          if (last) begin
            diff <= r_next;
            bout <= br_next;
            zero <= (r_next == '0);
            ovf  <= (a_msb != b_msb) && (r_next[WIDTH-1] != a_msb);
            done <= 1'b1;
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Directed and random checks for serial_subtractor, using an 8-bit and a
// 16-bit instance. Inputs are driven and outputs sampled on the falling
// edge of the clock.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst;

  logic        start8;
  logic [7:0]  in_a8, in_b8;
  logic        busy8, done8, bout8, zero8, ovf8;
  logic [7:0]  diff8;

  logic        start16;
  logic [15:0] in_a16, in_b16;
  logic        busy16, done16, bout16, zero16, ovf16;
  logic [15:0] diff16;

  int n_tests = 0;
  int n_fail  = 0;
  int excl_viol = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk  (clk),
    .rst  (rst),
    .start(start8),
    .inA  (in_a8),
    .inB  (in_b8),
    .busy (busy8),
    .done (done8),
    .diff (diff8),
    .bout (bout8),
    .zero (zero8),
    .ovf  (ovf8)
  );

  serial_subtractor #(.WIDTH(16)) dut16 (
    .clk  (clk),
    .rst  (rst),
    .start(start16),
    .inA  (in_a16),
    .inB  (in_b16),
    .busy (busy16),
    .done (done16),
    .diff (diff16),
    .bout (bout16),
    .zero (zero16),
    .ovf  (ovf16)
  );

  // busy and done must never be high together on either instance.
  always @(negedge clk) begin
    if (busy8 && done8)   excl_viol++;
    if (busy16 && done16) excl_viol++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- 8-bit helpers ----------------
  // Called at a falling edge. The next rising edge is the accepting edge.
  // The task returns at the falling edge that follows it.
  task automatic launch8(input logic [7:0] a, input logic [7:0] b);
    in_a8  = a;
    in_b8  = b;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    in_a8  = 8'hxx;
    in_b8  = 8'hxx;
    check("busy8_after_accept", 32'(busy8), 32'd1);
  endtask

  // Counts falling edges until done is seen, within a bound. A result
  // that lands WIDTH edges after the accept reports lat == WIDTH.
  task automatic wait_done8(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done8 && lat < 40);
  endtask

  task automatic check_res8(input string tag, input int lat,
                            input logic [7:0] e_diff, input logic e_bout,
                            input logic e_zero, input logic e_ovf);
    check({tag, "_latency"}, 32'(lat),    32'd8);
    check({tag, "_diff"},    32'(diff8),  32'(e_diff));
    check({tag, "_bout"},    32'(bout8),  32'(e_bout));
    check({tag, "_zero"},    32'(zero8),  32'(e_zero));
    check({tag, "_ovf"},     32'(ovf8),   32'(e_ovf));
  endtask

  task automatic count_done8(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done8) n++;
    end
  endtask

  // ---------------- 16-bit helpers ----------------
  task automatic launch16(input logic [15:0] a, input logic [15:0] b);
    in_a16  = a;
    in_b16  = b;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    in_a16  = 16'hxxxx;
    in_b16  = 16'hxxxx;
  endtask

  task automatic wait_done16(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done16 && lat < 60);
  endtask

  initial begin
    int lat;
    int n;
    logic [7:0]  ra8, rb8, ed8;
    logic [15:0] ra16, rb16, ed16;

    rst     = 1'b1;
    start8  = 1'b0;
    start16 = 1'b0;
    in_a8   = '0;
    in_b8   = '0;
    in_a16  = '0;
    in_b16  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_diff", 32'(diff8), 32'd0);
    check("rst_flags", {29'd0, bout8, zero8, ovf8}, 32'd0);
    check("rst_busy16", 32'(busy16), 32'd0);

    // Directed vectors, back-to-back: each launch starts on the done cycle
    // of the previous operation.
    @(negedge clk);
    launch8(8'h35, 8'h12); wait_done8(lat);
    check_res8("basic", lat, 8'h23, 1'b0, 1'b0, 1'b0);
    check("basic_busy_done", 32'(busy8), 32'd0);
    launch8(8'h12, 8'h35); wait_done8(lat);
    check_res8("borrow", lat, 8'hDD, 1'b1, 1'b0, 1'b0);
    launch8(8'h5A, 8'h5A); wait_done8(lat);
    check_res8("equal", lat, 8'h00, 1'b0, 1'b1, 1'b0);
    launch8(8'h80, 8'h01); wait_done8(lat);
    check_res8("ovf_neg", lat, 8'h7F, 1'b0, 1'b0, 1'b1);
    launch8(8'h7F, 8'hFF); wait_done8(lat);
    check_res8("ovf_pos", lat, 8'h80, 1'b1, 1'b0, 1'b1);

    // The done pulse lasts one cycle.
    @(negedge clk);
    check("done_drops", 32'(done8), 32'd0);

    // A start pulse 3 cycles into a busy op is ignored.
    launch8(8'h35, 8'h12);
    repeat (2) @(negedge clk);
    in_a8 = 8'hFF; in_b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(lat);
    check("ignore_latency", 32'(lat), 32'd5);
    check("ignore_diff", 32'(diff8), 32'h23);
    count_done8(20, n);
    check("ignore_no_extra_done", 32'(n), 32'd0);
    check("ignore_diff_held", 32'(diff8), 32'h23);

    // A start on the done cycle is accepted.
    @(negedge clk);
    launch8(8'h35, 8'h12); wait_done8(lat);
    check_res8("b2b_first", lat, 8'h23, 1'b0, 1'b0, 1'b0);
    launch8(8'h12, 8'h35); wait_done8(lat);
    check_res8("b2b_second", lat, 8'hDD, 1'b1, 1'b0, 1'b0);

    // Reset 4 cycles into an op aborts it.
    @(negedge clk);
    launch8(8'h80, 8'h01);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_done", 32'(done8), 32'd0);
    check("abort_diff", 32'(diff8), 32'd0);
    check("abort_flags", {29'd0, bout8, zero8, ovf8}, 32'd0);
    count_done8(20, n);
    check("abort_no_done", 32'(n), 32'd0);
    launch8(8'h35, 8'h12); wait_done8(lat);
    check_res8("after_abort", lat, 8'h23, 1'b0, 1'b0, 1'b0);

    // Random 8-bit operand pairs against the reference model.
    for (int i = 0; i < 1000; i++) begin
      ra8 = 8'($urandom);
      rb8 = 8'($urandom);
      ed8 = ra8 - rb8;
      launch8(ra8, rb8); wait_done8(lat);
      check_res8("rand8", lat, ed8, ra8 < rb8, ed8 == 8'h00,
                 (ra8[7] != rb8[7]) && (ed8[7] != ra8[7]));
    end

    // Random 16-bit operand pairs against the reference model.
    @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      ra16 = 16'($urandom);
      rb16 = 16'($urandom);
      if (i == 0) begin ra16 = 16'h8000; rb16 = 16'h0001; end
      if (i == 1) begin ra16 = 16'h1234; rb16 = 16'h1234; end
      ed16 = ra16 - rb16;
      launch16(ra16, rb16); wait_done16(lat);
      check("rand16_latency", 32'(lat),    32'd16);
      check("rand16_diff",    32'(diff16), 32'(ed16));
      check("rand16_bout",    32'(bout16), 32'(ra16 < rb16));
      check("rand16_zero",    32'(zero16), 32'(ed16 == 16'h0000));
      check("rand16_ovf",     32'(ovf16),
            32'((ra16[15] != rb16[15]) && (ed16[15] != ra16[15])));
    end

    @(negedge clk);
    check("busy_done_exclusive", 32'(excl_viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor that computes `inA - inB` one bit per clock, LSB first. It uses a single full-subtractor cell and a registered borrow, the sequential counterpart of the ALU's ripple full-adder datapath. It sits beside the ALU as a low-area subtract/compare unit. A `start`/`busy`/`done` handshake controls it, and it reports unsigned borrow, zero and signed-overflow flags.

## Interface
- `WIDTH`, 8, operand and result width in bits (≥ 2)
- `clk`  input  1  rising-edge clock; single clock domain
- `rst`  input  1  synchronous, active-high reset
- `start`  input  1  request; sampled only while not busy
- `inA`  input  WIDTH  minuend; captured on the accepting edge
- `inB`  input  WIDTH  subtrahend; captured on the accepting edge
- `busy`  output  1  high while a subtraction is in progress
- `done`  output  1  one-cycle pulse when results update
- `diff`  output  WIDTH  result `inA - inB` mod 2^WIDTH
- `bout`  output  1  final borrow; 1 iff `inA < inB` unsigned
- `zero`  output  1  1 iff `diff == 0`
- `ovf`  output  1  signed overflow of `inA - inB`

## Operation
- Reset: synchronous, active-high. All outputs are 0 after a `rst` edge, state = IDLE, and the operand/borrow/count registers are cleared.
- States:
  - IDLE -> SHIFT when `start`=1. On that edge: latch `inA`/`inB` into shift regs A, B; set borrow br=0 and count=0.
  - SHIFT: each edge, take a0=A[0] and b0=B[0].
    - d = a0 ^ b0 ^ br
    - br' = (~a0 & b0) | (~a0 & br) | (b0 & br)
    - Shift d into internal result reg R from the MSB side; shift A and B right; count++.
  - SHIFT -> IDLE on the edge that processes bit WIDTH-1 (count == WIDTH-1). On that edge:
    - `diff` <= final R
    - `bout` <= br'
    - `zero` <= (final R == 0)
    - `ovf` <= (inA[MSB] != inB[MSB]) && (final R[MSB] != inA[MSB])
    - `done` <= 1
- Outputs `diff`/`bout`/`zero`/`ovf` change only on the completion edge or on reset. They hold their values through the next operation until its completion.
- `start` while busy is ignored; it is neither queued nor re-sampled later.
- `start` in the same cycle `done`=1 is accepted, since the block is IDLE. Back-to-back operations need no gap cycle.
- Reset mid-operation aborts the operation: no `done` pulse, all outputs 0.
- `rst` has priority over `start` in the same cycle.

## Timing
- `start` sampled high at edge T (IDLE): `busy`=1 from T through T+WIDTH-1 edges.
- Completion edge is T+WIDTH: `busy`->0, `done`->1, results valid.
- `done` drops at edge T+WIDTH+1 unless a new completion occurs.
- Latency is WIDTH cycles from the accepting edge to valid results.
- Throughput is one result per WIDTH cycles.
- `busy` and `done` are never both 1.
- `inA`/`inB` need to be valid only at the accepting edge.

## Test plan
- Basic: WIDTH=8, 0x35 - 0x12 -> `done` exactly 8 cycles after accept; `diff`=0x23, `bout`=0, `zero`=0, `ovf`=0.
- Borrow and equal operands:
  - 0x12 - 0x35 -> `diff`=0xDD, `bout`=1, `ovf`=0.
  - 0x5A - 0x5A -> `diff`=0x00, `zero`=1, `bout`=0.
- Signed overflow:
  - 0x80 - 0x01 -> `diff`=0x7F, `ovf`=1, `bout`=0.
  - 0x7F - 0xFF -> `diff`=0x80, `ovf`=1, `bout`=1.
- Handshake:
  - Pulse `start` with 0xFF/0x01 at cycle 3 of a busy op -> ignored; the first op's result is unchanged and exactly one `done`.
  - `start` asserted on the `done` cycle -> second op accepted; its `done` arrives 8 cycles later.
- Reset: assert `rst` 4 cycles into an op -> next cycle all outputs 0 and no `done`; a fresh 0x35 - 0x12 then gives 0x23.
- Random: 1000 random operand pairs for WIDTH=8 and WIDTH=16. Compare `diff`/`bout`/`zero`/`ovf` against the reference model and check `done` timing every time.
